alu_writeback: RTL and testbench

Write-back stage directly downstream of the core ALU. It registers the ALU's result, flags and destination into a one-entry pipeline register, then commits them to an 8-entry general register file and the architectural flags register. It also serves the two operand read ports and the carry-in that feed the ALU. A secondary write port lets the load path write the register file, arbitrated against ALU commits by a ready handshake.

---
 rtl/alu_writeback.sv | 148 ++++++++++++++
 tb/tb_alu_writeback.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ----------------------------------------------------------------------------
// alu_writeback
//
// Write-back stage that sits directly after the core ALU. The ALU result,
// flags and destination are captured in a one-entry pipeline register and
// committed one cycle later to an 8-entry register file and to the
// architectural flags register. The stage also serves the ALU's two operand
// read ports and its carry-in, and accepts register writes from the load path
// whenever the pipeline register is not writing a register.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   wb_valid/opcode/dest/result/flags
//                         ALU output for this cycle
//   rd_addr1/2, rd_data1/2
//                         operand read ports (combinational, with bypass)
//   cin_out               carry-in to the ALU
//   flags_out             committed architectural flags
//   ext_valid/addr/data   load-path write request (held until accepted)
//   ext_ready             load write accepted this cycle
// ----------------------------------------------------------------------------
module alu_writeback #(
    parameter int WIDTH       = 32,
    parameter int OPCODE      = 4,
    parameter int REGS_CODING = 3,
    parameter int FLAGS       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic [OPCODE-1:0]      wb_opcode,
    input  logic [REGS_CODING-1:0] wb_dest,
    input  logic [WIDTH-1:0]       wb_result,
    input  logic [FLAGS-1:0]       wb_flags,
    input  logic [REGS_CODING-1:0] rd_addr1,
    input  logic [REGS_CODING-1:0] rd_addr2,
    output logic [WIDTH-1:0]       rd_data1,
    output logic [WIDTH-1:0]       rd_data2,
    output logic                   cin_out,
    output logic [FLAGS-1:0]       flags_out,
    input  logic                   ext_valid,
    input  logic [REGS_CODING-1:0] ext_addr,
    input  logic [WIDTH-1:0]       ext_data,
    output logic                   ext_ready
);

    localparam int CARRY    = 0;
    localparam int SIGN     = 1;
    localparam int OVERFLOW = 2;
    localparam int ZERO     = 3;
    localparam int NREGS    = 1 << REGS_CODING;

    localparam logic [OPCODE-1:0] OP_CMP = OPCODE'(12);

    // Opcodes whose flags replace the whole architectural flag vector.
    function automatic logic full_update(input logic [OPCODE-1:0] op);
        return (op == OPCODE'(0))  || (op == OPCODE'(1))  ||
               (op == OPCODE'(2))  || (op == OPCODE'(3))  ||
               (op == OPCODE'(12)) || (op == OPCODE'(13)) ||
               (op == OPCODE'(14));
    endfunction

    // Logical-class ops only define SIGN and ZERO; CARRY and OVERFLOW carry over.
    function automatic logic [FLAGS-1:0] merge_flags(
        input logic [FLAGS-1:0]  old_f,
        input logic [FLAGS-1:0]  new_f,
        input logic [OPCODE-1:0] op
    );
        logic [FLAGS-1:0] m;
        if (full_update(op)) begin
            m = new_f;
        end else begin
            m       = old_f;
            m[SIGN] = new_f[SIGN];
            m[ZERO] = new_f[ZERO];
        end
        return m;
    endfunction

    logic                   r_vld_p1;
    logic [OPCODE-1:0]      r_opcode_p1;
    logic [REGS_CODING-1:0] r_dest_p1;
    logic [WIDTH-1:0]       r_result_p1;
    logic [FLAGS-1:0]       r_flags_p1;

    logic [WIDTH-1:0]       r_regs [NREGS];
    logic [FLAGS-1:0]       r_flags;

    logic                   w_p_writes;
    logic                   w_ext_acc;

    assign w_p_writes = r_vld_p1 && (r_opcode_p1 != OP_CMP);
    assign ext_ready  = !w_p_writes;
    assign w_ext_acc  = ext_valid && ext_ready;

    // ---- stage p1: capture ALU output ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1    <= 1'b0;
            r_opcode_p1 <= '0;
            r_dest_p1   <= '0;
            r_result_p1 <= '0;
            r_flags_p1  <= '0;
        end else begin
            r_vld_p1    <= wb_valid;
            r_opcode_p1 <= wb_opcode;
            r_dest_p1   <= wb_dest;
            r_result_p1 <= wb_result;
            r_flags_p1  <= wb_flags;
        end
    end

    // ---- stage p2: commit to register file and flags ----
    // ALU commit and an accepted load never coexist, since ext_ready is low
    // exactly when the pipeline register writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_flags <= '0;
        end else begin
            if (w_p_writes) begin
                r_regs[r_dest_p1] <= r_result_p1;
            end else if (w_ext_acc) begin
                r_regs[ext_addr] <= ext_data;
            end
            if (r_vld_p1) begin
                r_flags <= merge_flags(r_flags, r_flags_p1, r_opcode_p1);
            end
        end
    end

    // Bypass only from registered state and load-path inputs, so there is no
    // combinational path from wb_* back into the ALU operands.
    assign rd_data1 = (w_p_writes && (rd_addr1 == r_dest_p1)) ? r_result_p1 :
                      (w_ext_acc  && (rd_addr1 == ext_addr))  ? ext_data    :
                      r_regs[rd_addr1];

    assign rd_data2 = (w_p_writes && (rd_addr2 == r_dest_p1)) ? r_result_p1 :
                      (w_ext_acc  && (rd_addr2 == ext_addr))  ? ext_data    :
                      r_regs[rd_addr2];

    assign cin_out   = (r_vld_p1 && full_update(r_opcode_p1)) ? r_flags_p1[CARRY]
                                                               : r_flags[CARRY];
    assign flags_out = r_flags;

endmodule

// File: tb/tb_alu_writeback.sv
// ----------------------------------------------------------------------------
// tb_alu_writeback
//
// Scoreboard bench for alu_writeback. Each stimulus cycle computes the
// architecturally visible state (committed registers plus the in-flight ALU
// result plus an accepted load) and pushes the expected port values; a
// monitor pops and compares them on the falling edge.
// ----------------------------------------------------------------------------
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [3:0]  wb_opcode;
    logic [2:0]  wb_dest;
    logic [31:0] wb_result;
    logic [3:0]  wb_flags;
    logic [2:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        cin_out;
    logic [3:0]  flags_out;
    logic        ext_valid;
    logic [2:0]  ext_addr;
    logic [31:0] ext_data;
    logic        ext_ready;

    always #5 clk = ~clk;

    alu_writeback #(.WIDTH(32), .OPCODE(4), .REGS_CODING(3), .FLAGS(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_dest(wb_dest),
        .wb_result(wb_result), .wb_flags(wb_flags),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .cin_out(cin_out), .flags_out(flags_out),
        .ext_valid(ext_valid), .ext_addr(ext_addr), .ext_data(ext_data),
        .ext_ready(ext_ready)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        cin;
        logic [3:0]  fl;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: committed architectural state and the op issued last cycle.
    logic [31:0] m_regs [8];
    logic [3:0]  m_flags;
    logic        inf_v;
    logic [3:0]  inf_op;
    logic [2:0]  inf_d;
    logic [31:0] inf_r;
    logic [3:0]  inf_f;

    // Load-path request, held until accepted.
    logic        ld_pend;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;

    function automatic logic is_full(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd12, 4'd13, 4'd14};
    endfunction

    function automatic logic [3:0] new_flags(input logic [3:0] old_f,
                                             input logic [3:0] op,
                                             input logic [3:0] f);
        if (is_full(op)) return f;
        return {f[3], old_f[2], f[1], old_f[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus its expected outputs.
    task automatic step(input logic rst, input logic v, input logic [3:0] op,
                        input logic [2:0] d, input logic [31:0] r, input logic [3:0] f,
                        input logic [2:0] a1, input logic [2:0] a2);
        logic [31:0] view [8];
        logic [3:0]  vfl;
        logic        rdy;
        logic        acc;
        exp_t        e;
        @(posedge clk);
        #1;
        reset     = rst;
        wb_valid  = v;
        wb_opcode = op;
        wb_dest   = d;
        wb_result = r;
        wb_flags  = f;
        rd_addr1  = a1;
        rd_addr2  = a2;
        ext_valid = ld_pend;
        ext_addr  = ld_addr;
        ext_data  = ld_data;

        // Visible register file: committed values, overlaid by the in-flight
        // ALU write, overlaid by a load accepted this cycle.
        view = m_regs;
        rdy  = !(inf_v && inf_op != 4'b1100);
        acc  = ld_pend && rdy;
        if (inf_v && inf_op != 4'b1100) view[inf_d] = inf_r;
        if (acc) view[ld_addr] = ld_data;
        vfl  = inf_v ? new_flags(m_flags, inf_op, inf_f) : m_flags;

        e.rd1 = view[a1];
        e.rd2 = view[a2];
        e.cin = vfl[0];
        e.fl  = m_flags;
        e.rdy = rdy;
        sb.push_back(e);

        if (acc || rst) ld_pend = 1'b0;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_flags = '0;
            inf_v = 1'b0; inf_op = '0; inf_d = '0; inf_r = '0; inf_f = '0;
        end else begin
            m_regs  = view;
            m_flags = vfl;
            inf_v = v; inf_op = op; inf_d = d; inf_r = r; inf_f = f;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_data1", rd_data1, e.rd1);
            chk("rd_data2", rd_data2, e.rd2);
            chk("cin_out", 32'(cin_out), 32'(e.cin));
            chk("flags_out", 32'(flags_out), 32'(e.fl));
            chk("ext_ready", 32'(ext_ready), 32'(e.rdy));
        end
    end

    initial begin
        reset = 1'b1; wb_valid = 0; wb_opcode = 0; wb_dest = 0; wb_result = 0;
        wb_flags = 0; rd_addr1 = 0; rd_addr2 = 0; ext_valid = 0; ext_addr = 0;
        ext_data = 0;
        ld_pend = 0; ld_addr = 0; ld_data = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_flags = 0; inf_v = 0; inf_op = 0; inf_d = 0; inf_r = 0; inf_f = 0;
        repeat (2) @(posedge clk);

        // Reset wins over a valid ALU output.
        step(1, 1, 4'd0, 3'd3, 32'h55, 4'hF, 3'd3, 3'd3);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd3, 3'd0);
        #3;
        chk("rst_rd3", rd_data1, 32'h0);
        chk("rst_ready", 32'(ext_ready), 32'h1);
        chk("rst_flags", 32'(flags_out), 32'h0);

        // ALU write, bypass then committed.
        step(0, 1, 4'b0000, 3'd2, 32'h1234, 4'b0001, 3'd2, 3'd0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd2, 3'd0);
        #3;
        chk("byp_rd2", rd_data1, 32'h1234);
        chk("byp_cin", 32'(cin_out), 32'h1);
        chk("byp_flags", 32'(flags_out), 32'h0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd2, 3'd0);
        #3;
        chk("commit_rd2", rd_data1, 32'h1234);
        chk("commit_flags", 32'(flags_out), 32'h1);

        // Partial flag update.
        step(0, 1, 4'b0000, 3'd0, 32'h0, 4'b0101, 3'd0, 3'd0);
        step(0, 1, 4'b0110, 3'd6, 32'h0, 4'b1000, 3'd0, 3'd0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd0, 3'd0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd0, 3'd0);
        #3;
        chk("partial_flags", 32'(flags_out), 32'hD);

        // Compare: no register write, full flag update.
        step(0, 1, 4'b1100, 3'd5, 32'h0, 4'b0110, 3'd5, 3'd0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd5, 3'd0);
        #3;
        chk("cmp_ready", 32'(ext_ready), 32'h1);
        chk("cmp_rd5", rd_data1, 32'h0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd5, 3'd0);
        #3;
        chk("cmp_flags", 32'(flags_out), 32'h6);

        // Load held across two back-to-back ALU writes.
        step(0, 1, 4'b0000, 3'd1, 32'h11, 4'h0, 3'd0, 3'd4);
        ld_pend = 1; ld_addr = 3'd4; ld_data = 32'hCAFE;
        step(0, 1, 4'b0000, 3'd7, 32'h77, 4'h0, 3'd0, 3'd4);
        #3;
        chk("ld_ready0a", 32'(ext_ready), 32'h0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd0, 3'd4);
        #3;
        chk("ld_ready0b", 32'(ext_ready), 32'h0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd0, 3'd4);
        #3;
        chk("ld_ready1", 32'(ext_ready), 32'h1);
        chk("ld_bypass", rd_data2, 32'hCAFE);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd0, 3'd4);
        #3;
        chk("ld_commit", rd_data2, 32'hCAFE);

        // Reset while P holds a write.
        step(0, 1, 4'b0000, 3'd1, 32'hFF, 4'h0, 3'd1, 3'd0);
        step(1, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd1, 3'd0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd1, 3'd4);
        #3;
        chk("midrst_rd1", rd_data1, 32'h0);
        chk("midrst_rd4", rd_data2, 32'h0);
        chk("midrst_ready", 32'(ext_ready), 32'h1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if (!ld_pend && $urandom_range(0, 3) == 0) begin
                ld_pend = 1;
                ld_addr = 3'($urandom_range(0, 7));
                ld_data = $urandom;
            end
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)),
                 $urandom,
                 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
        end

        ld_pend = 0;
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd0, 3'd0);
        step(0, 0, 4'd0, 3'd0, 32'h0, 4'h0, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
